// File: rtl/gba_rom_addr_seq.sv
// gba_rom_addr_seq
// Clocked GamePak address sequencer. The asynchronous cartridge strobes
// (CS/RD/WR) are synchronised onto CLK. The GBA address is latched when CS
// falls. The offset then advances after every completed strobe of a
// sequential burst. A write to BANK_REG_ADDR loads a bank register that
// extends the flash address above the GBA address width.
//
// Ports
//   CLK        system clock, at least 4x the GBA bus clock
//   RST        asynchronous, active-high reset
//   GBA_AD     multiplexed address/data from the GamePak
//   GBA_CS     chip select, active low
//   GBA_RD     read strobe, active low
//   GBA_WR     write strobe, active low
//   ROM_A      flash address {bank, offset}
//   ROM_OE_N   flash output enable, active low
//   BANK       current bank register value
//   PROTO_ERR  sticky bus-protocol error flag (cleared only by RST)

// Synchroniser for one asynchronous bus line. It drives the synchronised
// level and the previous synchronised level, so the parent can derive both
// edges. The chain resets to 1 because every GBA strobe is idle-high.
module gba_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic lvl,
    output logic prev
);
    logic [STAGES-1:0] pipe;
    logic              last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe <= '1;
            last <= 1'b1;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            last <= pipe[STAGES-1];
        end
    end

    assign lvl  = pipe[STAGES-1];
    assign prev = last;
endmodule

module gba_rom_addr_seq #(
    parameter int                ADDR_W        = 24,
    parameter int                BANK_W        = 4,
    parameter int                SYNC_STAGES   = 2,   // 2 or more
    parameter logic [ADDR_W-1:0] BANK_REG_ADDR = 24'hFFFFFE,
    parameter bit                INC_ON_WR     = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDR_W-1:0]        GBA_AD,
    input  logic                     GBA_CS,
    input  logic                     GBA_RD,
    input  logic                     GBA_WR,
    output logic [ADDR_W+BANK_W-1:0] ROM_A,
    output logic                     ROM_OE_N,
    output logic [BANK_W-1:0]        BANK,
    output logic                     PROTO_ERR
);
    // ------------------------------------------------------------------
    // Strobe synchronisers: line 0 = CS, 1 = RD, 2 = WR
    // ------------------------------------------------------------------
    localparam int NL = 3;

    logic [NL-1:0] pins, lvl, prev;

    assign pins = {GBA_WR, GBA_RD, GBA_CS};

    for (genvar i = 0; i < NL; i++) begin : g_sync
        gba_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .CLK  (CLK),
            .RST  (RST),
            .din  (pins[i]),
            .lvl  (lvl[i]),
            .prev (prev[i])
        );
    end

    logic cs_s, rd_s, wr_s;
    logic cs_fall, cs_rise, rd_rise, wr_rise;
    logic both_low;

    assign cs_s     = lvl[0];
    assign rd_s     = lvl[1];
    assign wr_s     = lvl[2];
    assign cs_fall  =  prev[0] & ~cs_s;
    assign cs_rise  = ~prev[0] &  cs_s;
    assign rd_rise  = ~prev[1] &  rd_s;
    assign wr_rise  = ~prev[2] &  wr_s;
    assign both_low = ~rd_s & ~wr_s;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]        offset;
    logic [ADDR_W-1:0]        offset_inc;
    logic [ADDR_W+BANK_W-1:0] rom_a;
    logic [BANK_W-1:0]        bank;
    logic                     proto_err;
    // dual_q remembers that RD and WR overlapped during this strobe. The
    // access then counts as a single read. A WR rise that comes before or
    // after the RD rise is neither a write nor a second increment. The flag
    // clears only once both strobes are high again.
    logic                     dual_q;

    // Natural wrap at 2^ADDR_W. The bank is not carried into.
    assign offset_inc = offset + ADDR_W'(1);

    // A WR rise is a real write only if it was never overlapped by RD.
    logic wr_commit;
    assign wr_commit = wr_rise & rd_s & ~dual_q;

    logic strobe_done;
    assign strobe_done = rd_rise | (INC_ON_WR & wr_commit);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LATCH   = 2'd1,
        S_STROBE  = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t st, nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) st <= S_IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt = st;
        unique case (st)
            S_IDLE:    if (cs_fall) nxt = S_LATCH;
            S_LATCH:   nxt = S_STROBE;
            S_STROBE:  if (strobe_done) nxt = S_ADVANCE;
            S_ADVANCE: nxt = S_STROBE;
        endcase
        // End of the chip-select window wins over everything, including a
        // strobe edge seen in the same cycle.
        if (cs_rise) nxt = S_IDLE;
    end

    logic rom_oe_n, do_latch, do_adv, bank_we;

    always_comb begin
        rom_oe_n = 1'b1;
        do_latch = 1'b0;
        do_adv   = 1'b0;
        bank_we  = 1'b0;
        unique case (st)
            S_IDLE:    ;
            S_LATCH:   do_latch = ~cs_rise;
            S_STROBE: begin
                rom_oe_n = rd_s | cs_s;
                bank_we  = wr_commit & ~cs_rise & (offset == BANK_REG_ADDR);
            end
            S_ADVANCE: do_adv = ~cs_rise;
        endcase
    end

    // ------------------------------------------------------------------
    // Address, bank and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            offset    <= '0;
            rom_a     <= '0;
            bank      <= '0;
            proto_err <= 1'b0;
            dual_q    <= 1'b0;
        end else begin
            // GBA_AD is stable for the whole latch window, so it is read
            // directly here without going through a synchroniser.
            if (do_latch) begin
                offset <= GBA_AD;
                rom_a  <= {bank, GBA_AD};
            end else if (do_adv) begin
                offset <= offset_inc;
                rom_a  <= {bank, offset_inc};
            end

            // The new bank reaches ROM_A at the next advance or latch.
            if (bank_we) bank <= GBA_AD[BANK_W-1:0];

            if (both_low)          dual_q <= 1'b1;
            else if (rd_s & wr_s)  dual_q <= 1'b0;

            if (both_low | (cs_s & (~rd_s | ~wr_s))) proto_err <= 1'b1;
        end
    end

    assign ROM_A     = rom_a;
    assign ROM_OE_N  = rom_oe_n;
    assign BANK      = bank;
    assign PROTO_ERR = proto_err;
endmodule

// File: tb/tb_gba_rom_addr_seq.sv
// Bench for gba_rom_addr_seq. Two instances share one bus: index 0 is
// built with INC_ON_WR=0 and index 1 with INC_ON_WR=1. Each read strobe
// pushes the expected {ROM_A, BANK, PROTO_ERR} into a per-instance queue.
// A monitor pops the queue when ROM_OE_N asserts. Writes show up through
// later reads and through the ROM_A/BANK values checked at the end of
// each burst.
module tb_gba_rom_addr_seq;
    localparam logic [23:0] BRA = 24'hFFFFFE;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] GBA_AD = '0;
    logic        GBA_CS = 1'b1, GBA_RD = 1'b1, GBA_WR = 1'b1;

    logic [1:0][27:0] rom_a;
    logic [1:0]       oe_n;
    logic [1:0][3:0]  bank;
    logic [1:0]       perr;

    always #5 CLK = ~CLK;

    gba_rom_addr_seq #(.INC_ON_WR(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .GBA_AD(GBA_AD), .GBA_CS(GBA_CS),
        .GBA_RD(GBA_RD), .GBA_WR(GBA_WR), .ROM_A(rom_a[0]),
        .ROM_OE_N(oe_n[0]), .BANK(bank[0]), .PROTO_ERR(perr[0]));

    gba_rom_addr_seq #(.INC_ON_WR(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .GBA_AD(GBA_AD), .GBA_CS(GBA_CS),
        .GBA_RD(GBA_RD), .GBA_WR(GBA_WR), .ROM_A(rom_a[1]),
        .ROM_OE_N(oe_n[1]), .BANK(bank[1]), .PROTO_ERR(perr[1]));

    typedef struct packed {
        logic [27:0] a;
        logic [3:0]  b;
        logic        e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors = 0;
    int errs    = 0;

    // Reference model: the bus-visible state of each instance.
    logic [23:0] m_off  [2];
    logic [3:0]  m_bank [2];
    logic [27:0] m_rom  [2];
    logic        m_err  [2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_off[k] = '0; m_bank[k] = '0; m_rom[k] = '0; m_err[k] = 1'b0;
        end
    endfunction

    function automatic void push_read();
        q0.push_back({m_rom[0], m_bank[0], m_err[0]});
        q1.push_back({m_rom[1], m_bank[1], m_err[1]});
    endfunction

    function automatic void model_advance(int k);
        m_off[k] = m_off[k] + 24'd1;
        m_rom[k] = {m_bank[k], m_off[k]};
    endfunction

    task automatic bus_start(logic [23:0] addr);
        GBA_AD = addr;
        GBA_CS = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_off[k] = addr;
            m_rom[k] = {m_bank[k], addr};
        end
        cyc(6);
    endtask

    task automatic op_read();
        push_read();
        GBA_RD = 1'b0;
        cyc($urandom_range(4, 6));
        GBA_RD = 1'b1;
        for (int k = 0; k < 2; k++) model_advance(k);
        cyc($urandom_range(5, 7));
    endtask

    task automatic op_write(logic [23:0] d);
        GBA_AD = d;
        GBA_WR = 1'b0;
        cyc($urandom_range(4, 6));
        GBA_WR = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (m_off[k] == BRA) m_bank[k] = d[3:0];
            if (k == 1) model_advance(k);
        end
        cyc($urandom_range(5, 7));
    endtask

    // RD and WR overlapping: error, one read, no bank load.
    task automatic op_dual();
        push_read();
        GBA_AD = 24'($urandom);
        GBA_RD = 1'b0;
        GBA_WR = 1'b0;
        cyc($urandom_range(4, 6));
        GBA_RD = 1'b1;
        GBA_WR = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b1;
            model_advance(k);
        end
        cyc($urandom_range(5, 7));
    endtask

    task automatic check_state(string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_rom_a%0d", tag, k), 32'(rom_a[k]), 32'(m_rom[k]));
            check($sformatf("%s_bank%0d", tag, k), 32'(bank[k]), 32'(m_bank[k]));
            check($sformatf("%s_perr%0d", tag, k), 32'(perr[k]), 32'(m_err[k]));
            check($sformatf("%s_oe_n%0d", tag, k), 32'(oe_n[k]), 32'd1);
        end
    endtask

    task automatic bus_end(string tag);
        cyc(2);
        GBA_CS = 1'b1;
        cyc(6);
        check_state(tag);
    endtask

    task automatic rand_burst(bit allow_dual);
        logic [23:0] base;
        int          nops;
        int          r;
        r    = $urandom_range(0, 3);
        base = (r == 0) ? (24'hFFFFFD + 24'($urandom_range(0, 2))) : 24'($urandom);
        bus_start(base);
        nops = $urandom_range(1, 5);
        for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 9);
            if (allow_dual && r == 0) op_dual();
            else if (r < 6)           op_read();
            else                      op_write(24'($urandom));
        end
        bus_end("rand_end");
    endtask

    // Monitor: a falling ROM_OE_N is the instance presenting a read.
    logic [1:0] prev_oe = 2'b11;

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (!RST && prev_oe[k] && !oe_n[k]) begin
                exp_t e;
                bit   got;
                got = 1'b0;
                e   = '0;
                if (k == 0) begin
                    if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                end else begin
                    if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                end
                if (!got) begin
                    vectors++;
                    errs++;
                    $display("FAIL oe_unexpected%0d: got OE with ROM_A %h, expected no read", k, rom_a[k]);
                end else begin
                    check($sformatf("rd_rom_a%0d", k), 32'(rom_a[k]), 32'(e.a));
                    check($sformatf("rd_bank%0d", k), 32'(bank[k]), 32'(e.b));
                    check($sformatf("rd_perr%0d", k), 32'(perr[k]), 32'(e.e));
                end
            end
        end
        prev_oe = oe_n;
    end

    initial begin
        model_reset();
        #1;
        check_state("reset");
        cyc(3);
        RST = 1'b0;
        cyc(3);

        // Single read
        bus_start(24'h001234);
        op_read();
        bus_end("single");

        // Burst of four across a 64K boundary
        bus_start(24'h00FFFE);
        repeat (4) op_read();
        bus_end("burst4");

        // Bank write, then a read in the new bank
        bus_start(BRA);
        op_write(24'h000005);
        bus_end("bankwr");
        bus_start(24'h000010);
        op_read();
        bus_end("bank5rd");

        // Bank 3, then wrap of the offset at 2^24
        bus_start(BRA);
        op_write(24'h000003);
        bus_end("bank3");
        bus_start(24'hFFFFFF);
        op_read();
        op_read();
        bus_end("wrap");

        // Write burst: only the INC_ON_WR=1 instance advances
        bus_start(24'h000100);
        repeat (3) op_write(24'($urandom_range(0, 255)));
        op_read();
        bus_end("wrburst");

        repeat (20) rand_burst(1'b0);

        // Overlapping RD/WR: sticky error
        bus_start(BRA);
        op_dual();
        op_read();
        bus_end("dual");
        bus_start(24'h000040);
        op_read();
        bus_end("dual_sticky");

        // Reset mid-burst while RD is held low
        bus_start(24'h000200);
        op_read();
        push_read();
        GBA_RD = 1'b0;
        cyc(5);
        RST = 1'b1;
        model_reset();
        #1;
        check_state("rst_mid");
        GBA_RD = 1'b1;
        GBA_CS = 1'b1;
        cyc(4);
        RST = 1'b0;
        cyc(4);
        check_state("rst_after");

        // Strobe while CS is high: error and ignored
        GBA_RD = 1'b0;
        cyc(5);
        GBA_RD = 1'b1;
        cyc(5);
        for (int k = 0; k < 2; k++) m_err[k] = 1'b1;
        check_state("cs_hi_strobe");
        RST = 1'b1;
        cyc(2);
        RST = 1'b0;
        model_reset();
        cyc(3);

        repeat (15) rand_burst(1'b1);

        cyc(10);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish before limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
        $fatal(1);
    end
endmodule
